tblock_dispatcher: RTL and testbench
====================================

Name: tblock_dispatcher

Overview:
- Kernel-launch scheduler sitting between the host/command interface and NumCus compute units.
- Accepts one launch (start PC, data/parameter address, thread-block count) and hands thread blocks one at a time to compute units that report a free warp.
- Assigns each block a unique in-flight block id, collects block-done handshakes, and signals launch completion once every block has finished.

Parameters:
- NumCus, 2, number of compute units served.
- PcWidth, 32, program counter width.
- AddressWidth, 32, data/parameter address width.
- TblockIdxBits, 4, block index width; a launch holds at most 2**TblockIdxBits blocks.
- TblockIdBits, 4, block id width; at most 2**TblockIdBits blocks may be in flight.

Ports:
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_valid_i  in  1  launch request.
- start_ready_o  out  1  dispatcher idle; launch accepted when valid&ready.
- start_pc_i  in  PcWidth  kernel entry PC.
- start_dp_addr_i  in  AddressWidth  data/parameter address.
- start_num_tblocks_i  in  TblockIdxBits+1  number of blocks, 0..2**TblockIdxBits.
- done_o  out  1  one-cycle pulse: launch complete.
- cu_warp_free_i  in  NumCus  CU can start a block.
- cu_allocate_warp_o  out  NumCus  one-hot allocate pulse.
- allocate_pc_o  out  PcWidth  latched start PC, shared by all CUs.
- allocate_dp_addr_o  out  AddressWidth  latched dp address, shared by all CUs.
- allocate_tblock_idx_o  out  TblockIdxBits  index of the block being allocated.
- allocate_tblock_id_o  out  TblockIdBits  id of the block being allocated.
- cu_tblock_done_i  in  NumCus  CU reports a finished block.
- cu_tblock_done_id_i  in  NumCus*TblockIdBits  id of the finished block, per CU.
- cu_tblock_done_ready_o  out  NumCus  one-hot accept of a done report.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - FSM goes to IDLE.
  - Id bitmap, counters, latched PC/address and the cooldown mask all clear.
  - Outputs during and after reset: start_ready_o=1, done_o=0, cu_allocate_warp_o=0, cu_tblock_done_ready_o=0, allocate_* = 0.
  - Reset mid-launch abandons the launch. No done_o is produced for it.
- FSM states: IDLE, DISPATCH, DRAIN, DONE.
  - IDLE: start_ready_o=1. On a start handshake, latch pc, dp address and count N, and clear the counters. N=0 goes to DONE; otherwise go to DISPATCH.
  - DISPATCH: an allocation fires in a cycle when (a) at least one id is free and (b) some CU is eligible. Eligible means cu_warp_free_i=1 and the CU was not allocated in the previous cycle (one-cycle cooldown covering the CU's free-flag update latency).
    - The CU is chosen by a round-robin pointer. The pointer advances past the granted CU.
    - The id is the lowest free id in the bitmap as it stood at the start of the cycle.
    - tblock_idx = dispatched count. cu_allocate_warp_o and allocate_* are combinational in the same cycle; there is no ready.
    - When the allocation with idx N-1 fires, go to DRAIN.
  - DRAIN: wait for completed count == N, then go to DONE.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Completion path, active in DISPATCH and DRAIN:
  - Round-robin over the asserted cu_tblock_done_i bits, with its own pointer. At most one ready bit is set per cycle.
  - On accept: clear that id in the bitmap and increment the completed count.
  - In IDLE and DONE all ready outputs are 0.
- Simultaneous allocate and complete in one cycle: both bitmap updates apply. The freed id becomes eligible the next cycle. An id freed and the lowest-free id chosen in the same cycle never collide.
- All ids in use: allocation stalls, with no allocate pulse, until a completion frees an id.
- A completion that arrives in the same cycle as the final allocation is counted. The transition to DONE then requires the count to reach N.
- Counters are TblockIdxBits+1 bits wide and never wrap, because N ≤ 2**TblockIdxBits.
- Simulation-only assertions:
  - A done id must not be free in the bitmap.
  - cu_allocate_warp_o and cu_tblock_done_ready_o are always one-hot-or-zero.

Test Plan:
- Single CU, N=3, cu_warp_free_i held 1 -> allocates at idx 0,1,2 on alternate cycles (cooldown), ids 0,1,2; completing ids in order 1,0,2 gives a done_o pulse one cycle after the completion count reaches 3.
- N=0 launch -> start accepted, done_o pulses 1 cycle later, no allocate pulse ever.
- Two CUs, both free, N=4 -> grants alternate CU0,CU1,CU0,CU1 on consecutive cycles; idx 0..3.
- TblockIdBits=1, N=4, no completions -> exactly two allocations (ids 0,1), then stall; completing id 0 lets idx 2 get id 0 on the next cycle.
- Both CUs assert done in the same cycle -> ready granted to one CU per cycle, round-robin; completed count increments by 1 per cycle.
- rst_i asserted in DRAIN with 2 blocks outstanding -> next cycle start_ready_o=1, all outputs 0, no done_o; a new launch runs normally.

Source files
------------

// File: rtl/tblock_dispatcher_if.sv
// Launch, allocation and completion signals between a dispatcher and its host/CU side.
// The dispatcher uses the slave modport; the host/CU side uses the master modport.
interface tblock_dispatcher_if #(
  parameter int NumCus        = 2,
  parameter int PcWidth       = 32,
  parameter int AddressWidth  = 32,
  parameter int TblockIdxBits = 4,
  parameter int TblockIdBits  = 4
);
  logic                           start_valid_i;
  logic                           start_ready_o;
  logic [PcWidth-1:0]             start_pc_i;
  logic [AddressWidth-1:0]        start_dp_addr_i;
  logic [TblockIdxBits:0]         start_num_tblocks_i;
  logic                           done_o;
  logic [NumCus-1:0]              cu_warp_free_i;
  logic [NumCus-1:0]              cu_allocate_warp_o;
  logic [PcWidth-1:0]             allocate_pc_o;
  logic [AddressWidth-1:0]        allocate_dp_addr_o;
  logic [TblockIdxBits-1:0]       allocate_tblock_idx_o;
  logic [TblockIdBits-1:0]        allocate_tblock_id_o;
  logic [NumCus-1:0]              cu_tblock_done_i;
  logic [NumCus*TblockIdBits-1:0] cu_tblock_done_id_i;
  logic [NumCus-1:0]              cu_tblock_done_ready_o;

  modport master (
    output start_valid_i, start_pc_i, start_dp_addr_i, start_num_tblocks_i,
           cu_warp_free_i, cu_tblock_done_i, cu_tblock_done_id_i,
    input  start_ready_o, done_o, cu_allocate_warp_o, allocate_pc_o,
           allocate_dp_addr_o, allocate_tblock_idx_o, allocate_tblock_id_o,
           cu_tblock_done_ready_o
  );

  modport slave (
    input  start_valid_i, start_pc_i, start_dp_addr_i, start_num_tblocks_i,
           cu_warp_free_i, cu_tblock_done_i, cu_tblock_done_id_i,
    output start_ready_o, done_o, cu_allocate_warp_o, allocate_pc_o,
           allocate_dp_addr_o, allocate_tblock_idx_o, allocate_tblock_id_o,
           cu_tblock_done_ready_o
  );
endinterface

// File: rtl/tblock_dispatcher.sv
// Kernel-launch scheduler: hands thread blocks to free CUs with unique in-flight ids
// and pulses done_o once every block of the launch has reported completion.
//
// state    | meaning
// IDLE     | ready for a launch
// DISPATCH | allocating blocks to eligible CUs, collecting completions
// DRAIN    | all blocks allocated, waiting for the remaining completions
// DONE     | one-cycle launch-complete pulse
module tblock_dispatcher #(
  parameter int NumCus        = 2,
  parameter int PcWidth       = 32,
  parameter int AddressWidth  = 32,
  parameter int TblockIdxBits = 4,
  parameter int TblockIdBits  = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  tblock_dispatcher_if.slave bus
);
  localparam int NumIds = 1 << TblockIdBits;
  localparam int CntW   = TblockIdxBits + 1;
  localparam int PtrW   = (NumCus > 1) ? $clog2(NumCus) : 1;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_e;
  state_e state_q, state_d;

  logic [PcWidth-1:0]      pc_q;
  logic [AddressWidth-1:0] dp_q;
  logic [CntW-1:0]         num_q, disp_cnt_q, cmpl_cnt_q;
  logic [NumIds-1:0]       id_busy_q, id_busy_d;
  logic [NumCus-1:0]       cooldown_q, eligible;
  logic [PtrW-1:0]         alloc_rr_q, cmpl_rr_q;

  logic                    start_fire;
  logic                    free_found;
  logic [TblockIdBits-1:0] free_id;
  logic                    alloc_fire, cmpl_fire;
  logic [NumCus-1:0]       alloc_oh, cmpl_oh;
  int                      alloc_gnt, cmpl_gnt;
  logic [TblockIdBits-1:0] cmpl_id;

  assign start_fire = (state_q == IDLE) && bus.start_valid_i;

  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = 0; i < NumIds; i++) begin
      if (!free_found && !id_busy_q[i]) begin
        free_found = 1'b1;
        free_id    = TblockIdBits'(i);
      end
    end
  end

  // Round-robin grant: first scan from the pointer upward, then wrap to the low CUs.
  always_comb begin
    alloc_oh   = '0;
    alloc_fire = 1'b0;
    alloc_gnt  = 0;
    eligible   = bus.cu_warp_free_i & ~cooldown_q;
    if (state_q == DISPATCH && free_found) begin
      for (int i = 0; i < NumCus; i++) begin
        if (!alloc_fire && i >= int'(alloc_rr_q) && eligible[i]) begin
          alloc_fire  = 1'b1;
          alloc_gnt   = i;
          alloc_oh[i] = 1'b1;
        end
      end
      for (int i = 0; i < NumCus; i++) begin
        if (!alloc_fire && eligible[i]) begin
          alloc_fire  = 1'b1;
          alloc_gnt   = i;
          alloc_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmpl_oh   = '0;
    cmpl_fire = 1'b0;
    cmpl_gnt  = 0;
    cmpl_id   = '0;
    if (state_q == DISPATCH || state_q == DRAIN) begin
      for (int i = 0; i < NumCus; i++) begin
        if (!cmpl_fire && i >= int'(cmpl_rr_q) && bus.cu_tblock_done_i[i]) begin
          cmpl_fire  = 1'b1;
          cmpl_gnt   = i;
          cmpl_oh[i] = 1'b1;
          cmpl_id    = bus.cu_tblock_done_id_i[i*TblockIdBits +: TblockIdBits];
        end
      end
      for (int i = 0; i < NumCus; i++) begin
        if (!cmpl_fire && bus.cu_tblock_done_i[i]) begin
          cmpl_fire  = 1'b1;
          cmpl_gnt   = i;
          cmpl_oh[i] = 1'b1;
          cmpl_id    = bus.cu_tblock_done_id_i[i*TblockIdBits +: TblockIdBits];
        end
      end
    end
  end

  // The allocated id is free and the completed id is busy, so the two updates never overlap.
  always_comb begin
    id_busy_d = id_busy_q;
    for (int i = 0; i < NumIds; i++) begin
      if (alloc_fire && free_id == TblockIdBits'(i)) id_busy_d[i] = 1'b1;
      if (cmpl_fire && cmpl_id == TblockIdBits'(i))  id_busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    bus.start_ready_o = 1'b0;
    bus.done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.start_ready_o = 1'b1;
        if (bus.start_valid_i)
          state_d = (bus.start_num_tblocks_i == '0) ? DONE : DISPATCH;
      end
      DISPATCH: if (alloc_fire && disp_cnt_q == num_q - CntW'(1)) state_d = DRAIN;
      DRAIN:    if (cmpl_cnt_q == num_q) state_d = DONE;
      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= '0;
      dp_q       <= '0;
      num_q      <= '0;
      disp_cnt_q <= '0;
      cmpl_cnt_q <= '0;
      id_busy_q  <= '0;
      cooldown_q <= '0;
      alloc_rr_q <= '0;
      cmpl_rr_q  <= '0;
    end else begin
      cooldown_q <= alloc_oh;
      id_busy_q  <= start_fire ? '0 : id_busy_d;
      if (start_fire) begin
        pc_q       <= bus.start_pc_i;
        dp_q       <= bus.start_dp_addr_i;
        num_q      <= bus.start_num_tblocks_i;
        disp_cnt_q <= '0;
        cmpl_cnt_q <= '0;
      end
      if (alloc_fire) begin
        disp_cnt_q <= disp_cnt_q + CntW'(1);
        alloc_rr_q <= (alloc_gnt == NumCus - 1) ? '0 : PtrW'(alloc_gnt + 1);
      end
      if (cmpl_fire) begin
        cmpl_cnt_q <= cmpl_cnt_q + CntW'(1);
        cmpl_rr_q  <= (cmpl_gnt == NumCus - 1) ? '0 : PtrW'(cmpl_gnt + 1);
      end
    end
  end

  assign bus.cu_allocate_warp_o     = alloc_oh;
  assign bus.cu_tblock_done_ready_o = cmpl_oh;
  assign bus.allocate_pc_o          = pc_q;
  assign bus.allocate_dp_addr_o     = dp_q;
  assign bus.allocate_tblock_idx_o  = (state_q == DISPATCH) ? disp_cnt_q[TblockIdxBits-1:0] : '0;
  assign bus.allocate_tblock_id_o   = (state_q == DISPATCH) ? free_id : '0;

  a_alloc_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(alloc_oh));
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(cmpl_oh));
  a_done_id_busy: assert property (@(posedge clk_i) disable iff (rst_i) cmpl_fire |-> id_busy_q[cmpl_id]);
endmodule

// File: tb/tb_tblock_dispatcher.sv
// Directed bench for tblock_dispatcher: a default instance (16 ids) and a 2-id instance
// exercising id exhaustion; all expected values are written out by hand.
module tb_tblock_dispatcher;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  tblock_dispatcher_if #(.TblockIdBits(4)) ifa ();
  tblock_dispatcher_if #(.TblockIdBits(1)) ifb ();

  tblock_dispatcher #(.TblockIdBits(4)) dut_a (.clk_i(clk_i), .rst_i(rst_i), .bus(ifa.slave));
  tblock_dispatcher #(.TblockIdBits(1)) dut_b (.clk_i(clk_i), .rst_i(rst_i), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Settle combinational outputs, then compare (well away from the clock edge).
  task automatic chk_a(input string tag, input logic [1:0] oh, input logic [3:0] idx, input logic [3:0] id);
    #2;
    chk({tag, " alloc"}, 32'(ifa.cu_allocate_warp_o), 32'(oh));
    if (oh != 2'b00) begin
      chk({tag, " idx"}, 32'(ifa.allocate_tblock_idx_o), 32'(idx));
      chk({tag, " id"},  32'(ifa.allocate_tblock_id_o),  32'(id));
    end
  endtask

  task automatic chk_b(input string tag, input logic [1:0] oh, input logic [3:0] idx, input logic id);
    #2;
    chk({tag, " alloc"}, 32'(ifb.cu_allocate_warp_o), 32'(oh));
    if (oh != 2'b00) begin
      chk({tag, " idx"}, 32'(ifb.allocate_tblock_idx_o), 32'(idx));
      chk({tag, " id"},  32'(ifb.allocate_tblock_id_o),  32'(id));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.start_valid_i = 0; ifa.start_pc_i = '0; ifa.start_dp_addr_i = '0; ifa.start_num_tblocks_i = '0;
    ifa.cu_warp_free_i = '0; ifa.cu_tblock_done_i = '0; ifa.cu_tblock_done_id_i = '0;
    ifb.start_valid_i = 0; ifb.start_pc_i = '0; ifb.start_dp_addr_i = '0; ifb.start_num_tblocks_i = '0;
    ifb.cu_warp_free_i = '0; ifb.cu_tblock_done_i = '0; ifb.cu_tblock_done_id_i = '0;

    // Reset state
    step(); step(); #2;
    chk("rst start_ready", 32'(ifa.start_ready_o), 32'h1);
    chk("rst done", 32'(ifa.done_o), 32'h0);
    chk("rst alloc", 32'(ifa.cu_allocate_warp_o), 32'h0);
    chk("rst ready", 32'(ifa.cu_tblock_done_ready_o), 32'h0);
    chk("rst pc", ifa.allocate_pc_o, 32'h0);
    chk("rst dp", ifa.allocate_dp_addr_o, 32'h0);
    rst_i = 0;
    step();

    // Single CU, N=3: cooldown spaces allocations; completions in order 1,0,2
    ifa.cu_warp_free_i = 2'b01;
    ifa.start_valid_i = 1; ifa.start_pc_i = 32'h1000; ifa.start_dp_addr_i = 32'h2000; ifa.start_num_tblocks_i = 5'd3;
    #2; chk("t1 start_ready", 32'(ifa.start_ready_o), 32'h1);
    step(); ifa.start_valid_i = 0;
    chk_a("t1 c1", 2'b01, 4'd0, 4'd0);
    chk("t1 pc", ifa.allocate_pc_o, 32'h1000);
    chk("t1 dp", ifa.allocate_dp_addr_o, 32'h2000);
    step(); chk_a("t1 c2", 2'b00, 4'd0, 4'd0);
    step(); chk_a("t1 c3", 2'b01, 4'd1, 4'd1);
    step(); chk_a("t1 c4", 2'b00, 4'd0, 4'd0);
    step(); chk_a("t1 c5", 2'b01, 4'd2, 4'd2);
    step(); chk_a("t1 drain", 2'b00, 4'd0, 4'd0);
    ifa.cu_tblock_done_i = 2'b01; ifa.cu_tblock_done_id_i = {4'd0, 4'd1};
    #2; chk("t1 ready id1", 32'(ifa.cu_tblock_done_ready_o), 32'h1);
    step(); ifa.cu_tblock_done_id_i = {4'd0, 4'd0};
    #2; chk("t1 ready id0", 32'(ifa.cu_tblock_done_ready_o), 32'h1);
    chk("t1 done early", 32'(ifa.done_o), 32'h0);
    step(); ifa.cu_tblock_done_id_i = {4'd0, 4'd2};
    #2; chk("t1 ready id2", 32'(ifa.cu_tblock_done_ready_o), 32'h1);
    step(); ifa.cu_tblock_done_i = 2'b00;
    #2; chk("t1 done count3", 32'(ifa.done_o), 32'h0);
    step(); #2;
    chk("t1 done pulse", 32'(ifa.done_o), 32'h1);
    chk("t1 busy in done", 32'(ifa.start_ready_o), 32'h0);
    step(); #2;
    chk("t1 done cleared", 32'(ifa.done_o), 32'h0);
    chk("t1 idle ready", 32'(ifa.start_ready_o), 32'h1);

    // N=0 launch: done next cycle, no allocation even with a free CU
    ifa.start_valid_i = 1; ifa.start_num_tblocks_i = 5'd0;
    step(); ifa.start_valid_i = 0;
    #2;
    chk("t2 done", 32'(ifa.done_o), 32'h1);
    chk("t2 alloc", 32'(ifa.cu_allocate_warp_o), 32'h0);
    step(); #2;
    chk("t2 done cleared", 32'(ifa.done_o), 32'h0);
    chk("t2 alloc after", 32'(ifa.cu_allocate_warp_o), 32'h0);
    chk("t2 idle", 32'(ifa.start_ready_o), 32'h1);

    // Reset to restart round-robin pointers, then two CUs free, N=4
    rst_i = 1; step(); rst_i = 0;
    ifa.cu_warp_free_i = 2'b11;
    ifa.start_valid_i = 1; ifa.start_pc_i = 32'h3000; ifa.start_num_tblocks_i = 5'd4;
    step(); ifa.start_valid_i = 0;
    chk_a("t3 c1", 2'b01, 4'd0, 4'd0);
    step(); chk_a("t3 c2", 2'b10, 4'd1, 4'd1);
    step(); chk_a("t3 c3", 2'b01, 4'd2, 4'd2);
    step(); chk_a("t3 c4", 2'b10, 4'd3, 4'd3);
    step(); chk_a("t3 drain", 2'b00, 4'd0, 4'd0);

    // Both CUs report done together: one ready per cycle, alternating
    ifa.cu_tblock_done_i = 2'b11; ifa.cu_tblock_done_id_i = {4'd1, 4'd0};
    #2; chk("t5 ready cu0", 32'(ifa.cu_tblock_done_ready_o), 32'h1);
    step(); ifa.cu_tblock_done_id_i = {4'd1, 4'd2};
    #2; chk("t5 ready cu1", 32'(ifa.cu_tblock_done_ready_o), 32'h2);
    step(); ifa.cu_tblock_done_id_i = {4'd3, 4'd2};
    #2; chk("t5 ready cu0 again", 32'(ifa.cu_tblock_done_ready_o), 32'h1);
    step(); ifa.cu_tblock_done_i = 2'b10;
    #2; chk("t5 ready cu1 last", 32'(ifa.cu_tblock_done_ready_o), 32'h2);
    chk("t5 done early", 32'(ifa.done_o), 32'h0);
    step(); ifa.cu_tblock_done_i = 2'b00;
    #2; chk("t5 done count4", 32'(ifa.done_o), 32'h0);
    step(); #2; chk("t5 done pulse", 32'(ifa.done_o), 32'h1);
    step();

    // Reset in DRAIN with two blocks outstanding, then a normal N=1 launch
    ifa.start_valid_i = 1; ifa.start_pc_i = 32'h4000; ifa.start_dp_addr_i = 32'h5000; ifa.start_num_tblocks_i = 5'd2;
    step(); ifa.start_valid_i = 0;
    chk_a("t6 c1", 2'b01, 4'd0, 4'd0);
    step(); chk_a("t6 c2", 2'b10, 4'd1, 4'd1);
    step(); chk_a("t6 drain", 2'b00, 4'd0, 4'd0);
    rst_i = 1;
    step(); #2;
    chk("t6 rst start_ready", 32'(ifa.start_ready_o), 32'h1);
    chk("t6 rst done", 32'(ifa.done_o), 32'h0);
    chk("t6 rst alloc", 32'(ifa.cu_allocate_warp_o), 32'h0);
    chk("t6 rst ready", 32'(ifa.cu_tblock_done_ready_o), 32'h0);
    chk("t6 rst pc", ifa.allocate_pc_o, 32'h0);
    chk("t6 rst dp", ifa.allocate_dp_addr_o, 32'h0);
    chk("t6 rst idx", 32'(ifa.allocate_tblock_idx_o), 32'h0);
    chk("t6 rst id", 32'(ifa.allocate_tblock_id_o), 32'h0);
    rst_i = 0;
    step(); #2; chk("t6 no done 1", 32'(ifa.done_o), 32'h0);
    step(); #2; chk("t6 no done 2", 32'(ifa.done_o), 32'h0);
    ifa.cu_warp_free_i = 2'b01;
    ifa.start_valid_i = 1; ifa.start_pc_i = 32'h6000; ifa.start_num_tblocks_i = 5'd1;
    step(); ifa.start_valid_i = 0;
    chk_a("t6 new c1", 2'b01, 4'd0, 4'd0);
    chk("t6 new pc", ifa.allocate_pc_o, 32'h6000);
    step(); chk_a("t6 new drain", 2'b00, 4'd0, 4'd0);
    ifa.cu_tblock_done_i = 2'b01; ifa.cu_tblock_done_id_i = {4'd0, 4'd0};
    #2; chk("t6 new ready", 32'(ifa.cu_tblock_done_ready_o), 32'h1);
    step(); ifa.cu_tblock_done_i = 2'b00;
    #2; chk("t6 new done early", 32'(ifa.done_o), 32'h0);
    step(); #2; chk("t6 new done", 32'(ifa.done_o), 32'h1);
    step();

    // Two-id instance, N=4: stalls once both ids are in flight
    ifb.cu_warp_free_i = 2'b01;
    ifb.start_valid_i = 1; ifb.start_pc_i = 32'h7000; ifb.start_num_tblocks_i = 5'd4;
    step(); ifb.start_valid_i = 0;
    chk_b("t4 A", 2'b01, 4'd0, 1'b0);
    step(); chk_b("t4 B", 2'b00, 4'd0, 1'b0);
    step(); chk_b("t4 C", 2'b01, 4'd1, 1'b1);
    step(); chk_b("t4 D", 2'b00, 4'd0, 1'b0);
    step(); chk_b("t4 E stall", 2'b00, 4'd0, 1'b0);
    step();
    ifb.cu_tblock_done_i = 2'b01; ifb.cu_tblock_done_id_i = {1'b0, 1'b0};
    chk_b("t4 F stall", 2'b00, 4'd0, 1'b0);
    chk("t4 F ready", 32'(ifb.cu_tblock_done_ready_o), 32'h1);
    step(); ifb.cu_tblock_done_i = 2'b00;
    chk_b("t4 G reuse id0", 2'b01, 4'd2, 1'b0);
    step(); ifb.cu_tblock_done_i = 2'b01; ifb.cu_tblock_done_id_i = {1'b0, 1'b1};
    chk_b("t4 H", 2'b00, 4'd0, 1'b0);
    chk("t4 H ready", 32'(ifb.cu_tblock_done_ready_o), 32'h1);
    step(); ifb.cu_tblock_done_id_i = {1'b0, 1'b0};
    chk_b("t4 I alloc+done", 2'b01, 4'd3, 1'b1);
    chk("t4 I ready", 32'(ifb.cu_tblock_done_ready_o), 32'h1);
    step(); ifb.cu_tblock_done_id_i = {1'b0, 1'b1};
    chk_b("t4 J drain", 2'b00, 4'd0, 1'b0);
    chk("t4 J ready", 32'(ifb.cu_tblock_done_ready_o), 32'h1);
    chk("t4 J done", 32'(ifb.done_o), 32'h0);
    step(); ifb.cu_tblock_done_i = 2'b00;
    #2; chk("t4 K done", 32'(ifb.done_o), 32'h0);
    step(); #2; chk("t4 L done pulse", 32'(ifb.done_o), 32'h1);
    step(); #2;
    chk("t4 M done cleared", 32'(ifb.done_o), 32'h0);
    chk("t4 M idle", 32'(ifb.start_ready_o), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
